// File: rtl/fb_access_arbiter_pkg.sv
// Shared constants and types for the framebuffer access arbiter.
// The display geometry is fixed here; address and data widths are defaults for the top.
package fb_access_arbiter_pkg;

  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int FB_PIXELS   = H_ACTIVE * V_ACTIVE;
  localparam int FB_ADDR_W   = 19;
  localparam int FB_DATA_W   = 8;
  localparam int FB_WQ_DEPTH = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_DISP  = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_t;

endpackage

// File: rtl/fb_write_queue.sv
// Posted host-write FIFO holding {addr, data} entries.
// A push is visible at the head no earlier than the following cycle.
module fb_write_queue #(
  parameter int AW    = 19,
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [AW-1:0] push_addr_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [AW-1:0] head_addr_o,
  output logic [DW-1:0] head_data_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_mem_q [DEPTH];
  logic [DW-1:0] data_mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push_s, do_pop_s;

  assign full_o      = (count_q == CW'(DEPTH));
  assign empty_o     = (count_q == CW'(0));
  assign do_push_s   = push_i && !full_o;
  assign do_pop_s    = pop_i && !empty_o;
  assign head_addr_o = addr_mem_q[rd_ptr_q];
  assign head_data_o = data_mem_q[rd_ptr_q];

  // Next-state pointers and occupancy; power-of-two depth gives natural wrap.
  always_comb begin
    wr_ptr_d = do_push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = do_pop_s  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Entry storage; contents past the pointers are don't-care so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      addr_mem_q[wr_ptr_q] <= push_addr_i;
      data_mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointer and occupancy registers; reset discards queued writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fb_access_arbiter.sv
// Single-port framebuffer arbiter: display reads win, posted host writes drain in blanking.
// Define FB_PAGE_SWAP_EN to enable front/back page double buffering.
module fb_access_arbiter
  import fb_access_arbiter_pkg::*;
#(
  parameter int ADDR_W   = FB_ADDR_W,
  parameter int DATA_W   = FB_DATA_W,
  parameter int WQ_DEPTH = FB_WQ_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              active_video_area,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_oor,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W:0]   mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pixel,
  output logic              pixel_valid
);

  localparam logic [ADDR_W-1:0] PIX_LIMIT = ADDR_W'(FB_PIXELS);

  arb_state_t        state_s;
  logic              full_s, empty_s, push_s, pop_s, head_oor_s;
  logic [ADDR_W-1:0] head_addr_s;
  logic [DATA_W-1:0] head_data_s;
  logic              disp_page_s, back_page_s;
  logic              rd_pend_q, rd_pend_d;
  logic              wr_oor_q, wr_oor_d;

  // Linear pixel address y*H_ACTIVE+x built from shifted copies of y.
  function automatic logic [ADDR_W-1:0] lin_addr(input logic [9:0] col, input logic [9:0] row);
    logic [ADDR_W-1:0] acc;
    acc = ADDR_W'(col);
    for (int i = 0; i < ADDR_W; i++) begin
      if (((H_ACTIVE >> i) & 1) != 0) begin
        acc = acc + (ADDR_W'(row) << i);
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction

  fb_write_queue #(
    .AW    (ADDR_W),
    .DW    (DATA_W),
    .DEPTH (WQ_DEPTH)
  ) u_wq (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_s),
    .push_addr_i (wr_addr),
    .push_data_i (wr_data),
    .pop_i       (pop_s),
    .head_addr_o (head_addr_s),
    .head_data_o (head_data_s),
    .full_o      (full_s),
    .empty_o     (empty_s)
  );

  assign wr_ready   = !full_s;
  assign push_s     = wr_valid && !full_s;
  assign pop_s      = (state_s == ARB_DRAIN);
  assign head_oor_s = (head_addr_s >= PIX_LIMIT);

  // Per-cycle arbitration decision; display reads are never stalled.
  always_comb begin
    if (rst) begin
      state_s = ARB_IDLE;
    end else if (active_video_area) begin
      state_s = ARB_DISP;
    end else if (!empty_s) begin
      state_s = ARB_DRAIN;
    end else begin
      state_s = ARB_IDLE;
    end
  end

  // SRAM strobes; an out-of-range head is popped with no access.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {(ADDR_W+1){1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    case (state_s)
      ARB_DISP: begin
        mem_en   = 1'b1;
        mem_addr = {disp_page_s, lin_addr(x, y)};
      end
      ARB_DRAIN: begin
        if (!head_oor_s) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = {back_page_s, head_addr_s};
          mem_wdata = head_data_s;
        end else begin
          mem_en = 1'b0;
        end
      end
      default: begin
        mem_en = 1'b0;
      end
    endcase
  end

  assign rd_pend_d = (state_s == ARB_DISP);
  assign wr_oor_d  = wr_oor_q | ((state_s == ARB_DRAIN) && head_oor_s);

  // Read-pending and sticky out-of-range flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_q <= 1'b0;
      wr_oor_q  <= 1'b0;
    end else begin
      rd_pend_q <= rd_pend_d;
      wr_oor_q  <= wr_oor_d;
    end
  end

  assign wr_oor      = wr_oor_q;
  assign pixel_valid = rd_pend_q;
  assign pixel       = rd_pend_q ? mem_rdata : {DATA_W{1'b0}};

`ifdef FB_PAGE_SWAP_EN
  logic disp_page_q, swap_pend_q, swap_ack_q;
  logic last_px_s, take_s;

  assign last_px_s = (state_s == ARB_DISP) && (x == 10'(H_ACTIVE - 1)) && (y == 10'(V_ACTIVE - 1));
  assign take_s    = last_px_s && swap_pend_q;

  // Page swap after the last pixel read; a request in the taking cycle is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_page_q <= 1'b0;
      swap_pend_q <= 1'b0;
      swap_ack_q  <= 1'b0;
    end else begin
      disp_page_q <= disp_page_q ^ take_s;
      swap_ack_q  <= take_s;
      swap_pend_q <= take_s ? swap_req : (swap_pend_q | swap_req);
    end
  end

  assign disp_page_s = disp_page_q;
  assign back_page_s = ~disp_page_q;
  assign swap_ack    = swap_ack_q;
`else
  logic unused_swap_req_s;

  assign unused_swap_req_s = swap_req;
  assign disp_page_s       = 1'b0;
  assign back_page_s       = 1'b0;
  assign swap_ack          = 1'b0;
`endif

endmodule
